// File: rtl/divider_n_bits_seq_pkg.sv
// Shared definitions for the sequential restoring divider and its users.
package divider_n_bits_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Base used by the decimal digit extraction clients (repeated /10, %10).
    localparam int DEC_BASE = 10;

endpackage

// File: rtl/subtractor_n_bits.sv
// Unsigned N-bit subtractor: diff = a - b (mod 2^N), borrow set when a < b.
module subtractor_n_bits #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] full;

    // One extra bit on the operands so that the borrow falls out as the MSB.
    assign full     = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full[N-1:0];
    assign borrow_o = full[N];

endmodule

// File: rtl/divider_n_bits_seq.sv
// Sequential restoring divider, N-bit unsigned. One quotient bit per cycle,
// results registered and held until the next accepted start.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for start, results of the last division held
//  S_RUN  | iterating, one quotient bit per clock
//  S_DONE | single-cycle done pulse; a new start is accepted here too
module divider_n_bits_seq
    import divider_n_bits_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         aclr_i,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_zero_o
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     rem_q, q_q, divisor_q;
    logic [N-1:0]     quotient_q, remainder_q;
    logic             div_zero_q;

    logic             accept;
    logic             divisor_is_zero;
    logic [N:0]       trial;
    logic [N:0]       trial_diff;
    logic             trial_borrow;
    logic             trial_fits;
    logic [N-1:0]     rem_d, q_d;

    assign accept          = start_i & ready_o;
    assign divisor_is_zero = (divisor_i == '0);

    // Trial step: shift the next dividend bit into the partial remainder and
    // subtract the divisor at N+1 bits so the borrow is the compare result.
    assign trial = {rem_q, q_q[N-1]};

    subtractor_n_bits #(
        .N(N + 1)
    ) u_trial_sub (
        .a_i     (trial),
        .b_i     ({1'b0, divisor_q}),
        .diff_o  (trial_diff),
        .borrow_o(trial_borrow)
    );

    // The difference MSB equals the borrow while rem < divisor holds, so the
    // OR is redundant in practice; it keeps every subtractor bit in use.
    assign trial_fits = ~(trial_borrow | trial_diff[N]);
    assign rem_d      = trial_fits ? trial_diff[N-1:0] : trial[N-1:0];
    assign q_d        = {q_q[N-2:0], trial_fits};

    // State register.
    always_ff @(posedge clk_i) begin
        if (aclr_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = divisor_is_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (start_i) state_d = divisor_is_zero ? S_DONE : S_RUN;
                else         state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_RUN:   busy_o  = 1'b1;
            S_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    // Working registers, iteration counter and result registers.
    always_ff @(posedge clk_i) begin
        if (aclr_i) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CNT_INIT;
            rem_q     <= '0;
            q_q       <= dividend_i;
            divisor_q <= divisor_i;
            // Divide-by-zero skips RUN, so its results are loaded right here.
            if (divisor_is_zero) begin
                quotient_q  <= '1;
                remainder_q <= dividend_i;
                div_zero_q  <= 1'b1;
            end else begin
                quotient_q  <= '0;
                remainder_q <= '0;
                div_zero_q  <= 1'b0;
            end
        end else if (state_q == S_RUN) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            if (cnt_q == '0) begin
                quotient_q  <= q_d;
                remainder_q <= rem_d;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = div_zero_q;

endmodule
